multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the EC413 multicycle CPU.
- Sequences the datapath through FETCH/DECODE/EXEC/MEM/WB for the 6-bit-opcode ISA: NOP, R-type 010xxx, I-type 110xxx, BEQ/BNE/BLT/BLE 1000xx, J 000001, LI/LUI/LWI/SWI/LW/SW 111001–111110.
- Drives PC/IR write enables, ALU op and operand selects, register-file writeback and data-memory strobes.
- Handles a ready handshake to data memory.

Parameters:
- WAIT_LIMIT, 16, max cycles in MEM awaiting mem_ready; 0 = wait forever.
- PC_W, 32, PC width (PC is word-indexed, increments by 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH
- zero  in  1  ALU result == 0
- lt  in  1  signed ALU A < B
- mem_ready  in  1  data memory accepts/completes the current access
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+1, 1 = zero-extended IR[15:0] (branch target), 2 = IR[25:0] (jump)
- ir_write  out  1  load IR from IMem
- reg_write  out  1  register-file write strobe
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = LI (low 16 bits), 3 = LUI (upper 16 bits, lower kept)
- alu_src_b  out  1  0 = register, 1 = extended immediate
- imm_sext  out  1  1 = sign-extend, 0 = zero-extend
- alu_op  out  3  MOV 000, NOT 001, ADD 010, SUB 011, OR 100, AND 101, XOR 110, SLT 111
- mem_read  out  1  data-memory read strobe
- mem_write  out  1  data-memory write strobe
- mem_addr_sel  out  1  0 = IR[15:0] absolute (LWI/SWI), 1 = ALU result rs+imm (LW/SW)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode
- mem_err  out  1  sticky; set on WAIT_LIMIT timeout; cleared only by reset
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4

Behaviour:
- Reset:
  - state = FETCH, mem_err = 0, wait counter = 0.
  - All outputs are forced 0 while reset is high.
  - Reset mid-instruction aborts it; no strobe fires after reset is asserted.
  - The first cycle after release is FETCH.
- FETCH: ir_write = 1, pc_write = 1, pc_src = 0. Always go to DECODE.
- DECODE (no strobes):
  - NOP or illegal opcode → FETCH; instr_done = 1; illegal = 1 only for an illegal opcode.
  - LI/LUI → WB.
  - All other opcodes → EXEC.
- EXEC:
  - ALU classes (R and I): alu_op = opcode[2:0]; alu_src_b = opcode[5]. → WB.
  - imm_sext = 1 for ADDI, SUBI and SLTI; imm_sext = 0 for ORI, ANDI and XORI.
  - Branch: alu_op = SUB. pc_write = taken, pc_src = 1. → FETCH, instr_done = 1.
    - BEQ taken = zero; BNE taken = !zero; BLT taken = lt; BLE taken = lt | zero.
  - J: pc_write = 1, pc_src = 2. → FETCH, instr_done = 1.
  - LW/SW: alu_op = ADD, alu_src_b = 1, imm_sext = 1. → MEM.
  - LWI/SWI: → MEM.
- MEM:
  - mem_read (loads) or mem_write (stores) is held high each cycle until mem_ready is sampled high; mem_addr_sel is held stable throughout.
  - On mem_ready: loads → WB; stores → FETCH with instr_done = 1. The strobe drops the next cycle.
  - The wait counter increments each cycle without mem_ready.
  - If WAIT_LIMIT ≠ 0 and the counter reaches WAIT_LIMIT: set mem_err, skip writeback, go to FETCH, instr_done = 1.
  - The counter clears on leaving MEM.
- WB: reg_write = 1; wb_sel per class (ALU 0, load 1, LI 2, LUI 3). → FETCH, instr_done = 1.
- Latency in cycles (excluding memory waits):
  - NOP: 2
  - LI/LUI, branch, J: 3
  - ALU, store: 4
  - load: 5
- mem_ready is ignored outside MEM.
- mem_ready high on the first MEM cycle means zero wait.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined: 32-bit outputs cycle_count (increments every cycle out of reset) and instr_count (increments on instr_done). Both wrap modulo 2^32 and reset to 0.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package ec413_ctrl_pkg holds:
  - opcode localparams (OP_NOP, OP_J, OP_BEQ..OP_BLE, OP_LI, OP_LUI, OP_LWI, OP_SWI, OP_LW, OP_SW);
  - state encodings;
  - pc_src, wb_sel and alu_op codes.
- Sub-module ctrl_op_class: combinational opcode classifier producing is_alu, is_imm, is_branch, is_jump, is_load, is_store, is_li, is_lui, is_illegal and zext.

Test Plan:
- Reset released, opcode = 000000 → states 0, 1, 0; instr_done pulses on the DECODE cycle; pc_write only in FETCH.
- ADDI (110010) → 4-cycle sequence; EXEC shows alu_op = 010, alu_src_b = 1, imm_sext = 1; WB shows reg_write = 1, wb_sel = 0.
- BNE (100001) with zero = 0 → EXEC shows pc_write = 1, pc_src = 1; repeat with zero = 1 → pc_write = 0 in EXEC.
- LW (111101) with mem_ready low for 3 cycles → mem_read held 4 cycles, then WB with wb_sel = 1; total 8 cycles.
- SWI (111100) with mem_ready stuck low and WAIT_LIMIT = 16 → mem_write high for 16 cycles, then mem_err = 1, FETCH, reg_write never asserted.
- Reset asserted during MEM of LWI → all outputs 0 immediately, state = 0; the first post-reset cycle is FETCH with ir_write = 1.

Source files
------------

// File: rtl/ec413_ctrl_pkg.sv
// Shared definitions for the EC413 multicycle control unit: opcodes, FSM state
// codes, datapath select codes and the decoded opcode-class bundle.
package ec413_ctrl_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_BNE = 6'b100001;
    localparam logic [5:0] OP_BLT = 6'b100010;
    localparam logic [5:0] OP_BLE = 6'b100011;
    localparam logic [5:0] OP_LI  = 6'b111001;
    localparam logic [5:0] OP_LUI = 6'b111010;
    localparam logic [5:0] OP_LWI = 6'b111011;
    localparam logic [5:0] OP_SWI = 6'b111100;
    localparam logic [5:0] OP_LW  = 6'b111101;
    localparam logic [5:0] OP_SW  = 6'b111110;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PC_SRC_INC    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_LI  = 2'd2,
        WB_LUI = 2'd3
    } wb_sel_t;

    typedef enum logic [2:0] {
        ALU_MOV = 3'b000,
        ALU_NOT = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_OR  = 3'b100,
        ALU_AND = 3'b101,
        ALU_XOR = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic is_alu;
        logic is_imm;
        logic is_branch;
        logic is_jump;
        logic is_load;
        logic is_store;
        logic is_li;
        logic is_lui;
        logic is_illegal;
        logic zext;
    } op_class_t;

    // Branch condition is selected by the low two opcode bits (BEQ, BNE, BLT, BLE).
    function automatic logic branch_taken(input logic [1:0] cond, input logic zero,
                                          input logic lt);
        case (cond)
            2'b00:   return zero;
            2'b01:   return !zero;
            2'b10:   return lt;
            default: return lt | zero;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational opcode classifier for the EC413 control FSM.
module ctrl_op_class
    import ec413_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_class
);

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        o_class = '0;
        casez (i_opcode)
            OP_NOP:    o_class = '0;
            OP_J:      o_class.is_jump = 1'b1;
            6'b010???: o_class.is_alu = 1'b1;
            6'b110???: begin
                o_class.is_alu = 1'b1;
                o_class.is_imm = 1'b1;
                // Only the arithmetic immediates take a signed operand.
                o_class.zext   = (i_opcode[2:0] != ALU_ADD) && (i_opcode[2:0] != ALU_SUB)
                              && (i_opcode[2:0] != ALU_SLT);
            end
            6'b1000??: o_class.is_branch = 1'b1;
            OP_LI:     o_class.is_li = 1'b1;
            OP_LUI:    o_class.is_lui = 1'b1;
            OP_LWI:    o_class.is_load = 1'b1;
            OP_LW:     o_class.is_load = 1'b1;
            OP_SWI:    o_class.is_store = 1'b1;
            OP_SW:     o_class.is_store = 1'b1;
            default:   o_class.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the EC413 multicycle CPU (FETCH/DECODE/EXEC/MEM/WB).
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle and retired-instruction counters.
module multicycle_ctrl
    import ec413_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int PC_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        lt,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic        imm_sext,
    output logic [2:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_addr_sel,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_err,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    if (PC_W < 26) begin : g_pc_w_chk
        $error("PC_W must be wide enough for a 26-bit jump target");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_inc;
    logic             r_mem_err;
    logic             w_timeout;
    logic             w_rs_addr;
    op_class_t        w_cls;

    ctrl_op_class u_op_class (
        .i_opcode (opcode),
        .o_class  (w_cls)
    );

    assign w_rs_addr  = (opcode == OP_LW) || (opcode == OP_SW);
    assign w_wait_inc = r_wait_cnt + CNT_W'(1);
    assign w_timeout  = (WAIT_LIMIT != 0) && (r_state == ST_MEM) && !mem_ready
                     && (w_wait_inc == CNT_W'(WAIT_LIMIT));

    // Branch and memory cycles react to zero/lt/mem_ready within the same cycle,
    // so the strobes are decoded from state rather than registered.
    always_comb begin
        w_state_nxt  = r_state;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_INC;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        alu_src_b    = 1'b0;
        imm_sext     = 1'b0;
        alu_op       = ALU_MOV;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            ST_FETCH: begin
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_cls.is_illegal || opcode == OP_NOP) begin
                    instr_done  = 1'b1;
                    illegal     = w_cls.is_illegal;
                    w_state_nxt = ST_FETCH;
                end else if (w_cls.is_li || w_cls.is_lui) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                if (w_cls.is_alu) begin
                    alu_op      = opcode[2:0];
                    alu_src_b   = opcode[5];
                    imm_sext    = w_cls.is_imm && !w_cls.zext;
                    w_state_nxt = ST_WB;
                end else if (w_cls.is_branch) begin
                    alu_op     = ALU_SUB;
                    pc_src     = PC_SRC_BRANCH;
                    pc_write   = branch_taken(opcode[1:0], zero, lt);
                    instr_done = 1'b1;
                end else if (w_cls.is_jump) begin
                    pc_src     = PC_SRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end else if (w_cls.is_load || w_cls.is_store) begin
                    if (w_rs_addr) begin
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                        imm_sext  = 1'b1;
                    end
                    w_state_nxt = ST_MEM;
                end
            end
            ST_MEM: begin
                mem_read     = w_cls.is_load;
                mem_write    = w_cls.is_store;
                mem_addr_sel = w_rs_addr;
                if (mem_ready) begin
                    instr_done  = w_cls.is_store;
                    w_state_nxt = w_cls.is_load ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    instr_done  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write   = 1'b1;
                wb_sel      = w_cls.is_load ? WB_MEM :
                              w_cls.is_li   ? WB_LI  :
                              w_cls.is_lui  ? WB_LUI : WB_ALU;
                instr_done  = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_FETCH;
        endcase

        // Reset silences every strobe immediately, even mid-instruction.
        if (reset) begin
            pc_write     = 1'b0;
            pc_src       = PC_SRC_INC;
            ir_write     = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = WB_ALU;
            alu_src_b    = 1'b0;
            imm_sext     = 1'b0;
            alu_op       = ALU_MOV;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_addr_sel = 1'b0;
            instr_done   = 1'b0;
            illegal      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= (r_state == ST_MEM && w_state_nxt == ST_MEM) ? w_wait_inc : '0;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign state   = r_state;
    assign mem_err = r_mem_err;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (instr_done) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are
// queued as stimulus is applied and compared on the falling edge.
module tb_multicycle_ctrl;

    localparam int WAIT_LIMIT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        lt = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, reg_write, alu_src_b, imm_sext;
    logic        mem_read, mem_write, mem_addr_sel, instr_done, illegal, mem_err;
    logic [1:0]  pc_src, wb_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] cycle_count, instr_count;

    multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .imm_sext(imm_sext), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
        .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err),
        .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_b;
        logic       imm_sext;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_addr_sel;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
        logic [2:0] state;
    } ctl_t;

    typedef struct {
        string      tag;
        logic [5:0] op;
        logic       z;
        logic       l;
        logic       rdy;
        ctl_t       exp;
    } cyc_t;

    typedef struct {
        string tag;
        ctl_t  exp;
    } sb_t;

    ctl_t act;
    assign act = {pc_write, pc_src, ir_write, reg_write, wb_sel, alu_src_b, imm_sext,
                  alu_op, mem_read, mem_write, mem_addr_sel, instr_done, illegal,
                  mem_err, state};

    cyc_t stim_q[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic m_err = 1'b0;
    int   m_cycles = 0;
    int   m_instr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t c;
        c = '0;
        c.state = st;
        c.mem_err = m_err;
        return c;
    endfunction

    task automatic push(input string tag, input logic [5:0] op, input logic z, input logic l,
                        input logic rdy, input ctl_t e);
        cyc_t p;
        p.tag = tag; p.op = op; p.z = z; p.l = l; p.rdy = rdy; p.exp = e;
        stim_q.push_back(p);
    endtask

    // Expected control sequence for one instruction, cycle by cycle.
    task automatic gen(input string name, input logic [5:0] op, input logic z, input logic l,
                       input int mem_wait);
        ctl_t c;
        logic is_r, is_i, is_br, is_j, is_ld, is_st, is_li, is_lui, is_nop, is_ill, rs_addr;
        logic rdy, taken;
        is_r    = (op[5:3] == 3'b010);
        is_i    = (op[5:3] == 3'b110);
        is_br   = (op[5:2] == 4'b1000);
        is_j    = (op == 6'b000001);
        is_nop  = (op == 6'b000000);
        is_li   = (op == 6'b111001);
        is_lui  = (op == 6'b111010);
        is_ld   = (op == 6'b111011) || (op == 6'b111101);
        is_st   = (op == 6'b111100) || (op == 6'b111110);
        rs_addr = (op == 6'b111101) || (op == 6'b111110);
        is_ill  = !(is_r || is_i || is_br || is_j || is_nop || is_li || is_lui || is_ld || is_st);

        c = base(3'd0); c.ir_write = 1'b1; c.pc_write = 1'b1;
        push({name, "/F"}, op, z, l, 1'b1, c);

        c = base(3'd1);
        if (is_nop || is_ill) begin
            c.instr_done = 1'b1; c.illegal = is_ill;
            push({name, "/D"}, op, z, l, 1'b1, c);
            return;
        end
        push({name, "/D"}, op, z, l, 1'b1, c);

        if (!(is_li || is_lui)) begin
            c = base(3'd2);
            if (is_r || is_i) begin
                c.alu_op = op[2:0]; c.alu_src_b = is_i;
                c.imm_sext = is_i && (op[2:0] inside {3'b010, 3'b011, 3'b111});
                push({name, "/E"}, op, z, l, 1'b1, c);
            end else if (is_br) begin
                case (op[1:0])
                    2'b00:   taken = z;
                    2'b01:   taken = !z;
                    2'b10:   taken = l;
                    default: taken = l || z;
                endcase
                c.alu_op = 3'b011; c.pc_src = 2'd1; c.pc_write = taken; c.instr_done = 1'b1;
                push({name, "/E"}, op, z, l, 1'b1, c);
                return;
            end else if (is_j) begin
                c.pc_src = 2'd2; c.pc_write = 1'b1; c.instr_done = 1'b1;
                push({name, "/E"}, op, z, l, 1'b1, c);
                return;
            end else begin
                if (rs_addr) begin
                    c.alu_op = 3'b010; c.alu_src_b = 1'b1; c.imm_sext = 1'b1;
                end
                push({name, "/E"}, op, z, l, 1'b1, c);
                for (int i = 0; ; i++) begin
                    rdy = (i >= mem_wait);
                    c = base(3'd3);
                    c.mem_read = is_ld; c.mem_write = is_st; c.mem_addr_sel = rs_addr;
                    if (rdy) begin
                        c.instr_done = is_st;
                        push($sformatf("%s/M%0d", name, i), op, z, l, 1'b1, c);
                        if (is_st) return;
                        break;
                    end else if (i == WAIT_LIMIT - 1) begin
                        c.instr_done = 1'b1;
                        push($sformatf("%s/M%0d", name, i), op, z, l, 1'b0, c);
                        m_err = 1'b1;
                        return;
                    end
                    push($sformatf("%s/M%0d", name, i), op, z, l, 1'b0, c);
                end
            end
        end

        c = base(3'd4);
        c.reg_write = 1'b1; c.instr_done = 1'b1;
        c.wb_sel = is_ld ? 2'd1 : is_li ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        push({name, "/W"}, op, z, l, 1'b1, c);
    endtask

    // Applies queued cycles just after each rising edge; drops whatever is left.
    task automatic drive(input int max_cycles);
        cyc_t p;
        int   n = 0;
        while (stim_q.size() != 0 && n < max_cycles) begin
            p = stim_q.pop_front();
            opcode = p.op; zero = p.z; lt = p.l; mem_ready = p.rdy;
            sb_q.push_back('{tag: p.tag, exp: p.exp});
            if (p.exp.instr_done) m_instr++;
            @(posedge clk);
            #1;
            m_cycles++;
            n++;
        end
        stim_q.delete();
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic z, input logic l,
                       input int mem_wait);
        gen(name, op, z, l, mem_wait);
        drive(1000);
    endtask

    always @(negedge clk) begin
        sb_t s;
        if (sb_q.size() != 0) begin
            s = sb_q.pop_front();
            check(s.tag, 32'(act), 32'(s.exp));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run("nop",     6'b000000, 1'b0, 1'b0, 0);
        run("addi",    6'b110010, 1'b0, 1'b0, 0);
        run("ori",     6'b110100, 1'b0, 1'b0, 0);
        run("slt_r",   6'b010111, 1'b0, 1'b0, 0);
        run("bne_nz",  6'b100001, 1'b0, 1'b0, 0);
        run("bne_z",   6'b100001, 1'b1, 1'b0, 0);
        run("beq_z",   6'b100000, 1'b1, 1'b0, 0);
        run("blt_lt",  6'b100010, 1'b0, 1'b1, 0);
        run("ble_z",   6'b100011, 1'b1, 1'b0, 0);
        run("ble_nt",  6'b100011, 1'b0, 1'b0, 0);
        run("j",       6'b000001, 1'b0, 1'b0, 0);
        run("li",      6'b111001, 1'b0, 1'b0, 0);
        run("lui",     6'b111010, 1'b0, 1'b0, 0);
        run("lw_w3",   6'b111101, 1'b0, 1'b0, 3);
        run("sw_w0",   6'b111110, 1'b0, 1'b0, 0);
        run("lwi_w1",  6'b111011, 1'b0, 1'b0, 1);
        run("illegal", 6'b011111, 1'b0, 1'b0, 0);
        run("swi_to",  6'b111100, 1'b0, 1'b0, 100);
        run("addi_err", 6'b110010, 1'b0, 1'b0, 0);

        gen("lwi_rst", 6'b111011, 1'b0, 1'b0, 10);
        drive(4);
        check("pre_rst_state", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        check("rst_async", 32'(act), 32'd0);
        @(negedge clk);
        check("rst_hold", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_err = 1'b0;
        m_cycles = 0;
        m_instr = 0;

        run("nop_post", 6'b000000, 1'b0, 1'b0, 0);
        run("sw_post",  6'b111110, 1'b0, 1'b0, 2);

`ifdef MULTICYCLE_CTRL_PERF_EN
        check("cycle_count", cycle_count, 32'(m_cycles));
        check("instr_count", instr_count, 32'(m_instr));
`else
        check("cycle_count_tied", cycle_count, 32'd0);
        check("instr_count_tied", instr_count, 32'd0);
`endif
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
